// File: rtl/coca_vend_ctrl_if.sv
// Key/display/status bundle between the vending controller and its neighbours.
interface coca_vend_ctrl_if;
  logic [3:0]  flag_key;      // [0] coin 0.5, [1] coin 1.0, [2] buy, [3] cancel
  logic [23:0] rNum;          // BCD credit for the 7-segment scanner
  logic        dispense;
  logic        change_pulse;
  logic        reject;
  logic [3:0]  led;

  // Key source side (debouncer / testbench)
  modport master (
    output flag_key,
    input  rNum, dispense, change_pulse, reject, led
  );

  // Controller side
  modport slave (
    input  flag_key,
    output rNum, dispense, change_pulse, reject, led
  );
endinterface

// File: rtl/coca_vend_ctrl.sv
// Vending transaction controller: coin credit, product dispense and change payout.
module coca_vend_ctrl #(
  parameter int unsigned PRICE       = 25,
  parameter int unsigned CREDIT_MAX  = 95,
  parameter int unsigned DISP_CYCLES = 50_000_000,
  parameter int unsigned PULSE_HI    = 5_000_000,
  parameter int unsigned PULSE_LO    = 5_000_000
) (
  input logic              sclk,
  input logic              rst,
  coca_vend_ctrl_if.slave  bus
);

  // Payout is split into high and low phases; both report CHANGE on the LEDs.
  typedef enum logic [2:0] {StIdle, StCredit, StVend, StChgHi, StChgLo} state_e;

  // One shared timer, wide enough for the longest phase.
  localparam int unsigned TMax0 = (DISP_CYCLES > PULSE_HI) ? DISP_CYCLES : PULSE_HI;
  localparam int unsigned TMax  = (TMax0 > PULSE_LO) ? TMax0 : PULSE_LO;
  localparam int unsigned TW    = (TMax > 1) ? $clog2(TMax) : 1;

  localparam logic [TW-1:0] DispLast = TW'(DISP_CYCLES - 1);
  localparam logic [TW-1:0] HiLast   = TW'(PULSE_HI - 1);
  localparam logic [TW-1:0] LoLast   = TW'(PULSE_LO - 1);
  localparam logic [6:0]    Price7   = 7'(PRICE);
  localparam logic [6:0]    Max7     = 7'(CREDIT_MAX);

  state_e        state_q, state_d;
  logic [6:0]    credit_q, credit_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          reject_q, reject_d;
  logic          dispense_q, change_pulse_q;
  logic [3:0]    led_q, led_d;
  logic [23:0]   rnum_q, rnum_d;

  logic       ev_cancel, ev_buy, ev_c10, ev_c5, ev_coin;
  logic [6:0] coin_val, coin_sum;

  // Priority arbitration: cancel > buy > coin 1.0 > coin 0.5.
  always_comb begin
    ev_cancel = bus.flag_key[3];
    ev_buy    = (bus.flag_key[3:2] == 2'b01);
    ev_c10    = (bus.flag_key[3:1] == 3'b001);
    ev_c5     = (bus.flag_key == 4'b0001);
    ev_coin   = ev_c10 | ev_c5;
    coin_val  = ev_c10 ? 7'd10 : 7'd5;
    coin_sum  = credit_q + coin_val;   // at most 99 + 10, fits in 7 bits
  end

  // Next-state, credit and timer update.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    timer_d  = timer_q;
    reject_d = 1'b0;
    unique case (state_q)
      StIdle, StCredit: begin
        if (ev_cancel) begin
          if (credit_q != 7'd0) begin
            state_d = StChgHi;
            timer_d = '0;
          end
        end else if (ev_buy) begin
          if (credit_q >= Price7) begin
            credit_d = credit_q - Price7;
            state_d  = StVend;
            timer_d  = '0;
          end else begin
            reject_d = 1'b1;
          end
        end else if (ev_coin) begin
          if (coin_sum <= Max7) begin
            credit_d = coin_sum;
            state_d  = StCredit;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      StVend: begin
        if (timer_q == DispLast) begin
          timer_d = '0;
          state_d = (credit_q != 7'd0) ? StChgHi : StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StChgHi: begin
        reject_d = ev_coin;
        if (timer_q == HiLast) begin
          timer_d  = '0;
          credit_d = credit_q - 7'd5;
          state_d  = StChgLo;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StChgLo: begin
        reject_d = ev_coin;
        if (timer_q == LoLast) begin
          timer_d = '0;
          state_d = (credit_q != 7'd0) ? StChgHi : StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // LED decode from the current state and BCD conversion of current credit.
  always_comb begin
    led_d = 4'b0001;
    unique case (state_q)
      StIdle:           led_d = 4'b0001;
      StCredit:         led_d = 4'b0010;
      StVend:           led_d = 4'b0100;
      StChgHi, StChgLo: led_d = 4'b1000;
      default:          led_d = 4'b0001;
    endcase
    rnum_d = {16'h0000, 4'(credit_q / 7'd10), 4'(credit_q % 7'd10)};
  end

  // State, credit and registered outputs; reset drops everything at once.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      credit_q       <= 7'd0;
      timer_q        <= '0;
      reject_q       <= 1'b0;
      dispense_q     <= 1'b0;
      change_pulse_q <= 1'b0;
      led_q          <= 4'b0001;
      rnum_q         <= 24'h000000;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      timer_q        <= timer_d;
      reject_q       <= reject_d;
      dispense_q     <= (state_d == StVend);
      change_pulse_q <= (state_d == StChgHi);
      led_q          <= led_d;
      rnum_q         <= rnum_d;
    end
  end

  assign bus.rNum         = rnum_q;
  assign bus.dispense     = dispense_q;
  assign bus.change_pulse = change_pulse_q;
  assign bus.reject       = reject_q;
  assign bus.led          = led_q;

endmodule

// File: tb/tb_coca_vend_ctrl.sv
// Bench for coca_vend_ctrl: directed scenarios plus random key sequences
// checked against a transaction-level credit model.
module tb_coca_vend_ctrl;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  always #5 sclk = ~sclk;

  coca_vend_ctrl_if bus ();

  coca_vend_ctrl #(
    .PRICE      (25),
    .CREDIT_MAX (95),
    .DISP_CYCLES(4),
    .PULSE_HI   (2),
    .PULSE_LO   (2)
  ) dut (
    .sclk(sclk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int credit_m = 0;  // model credit, 0.1-yuan units

  // Observations gathered by settle()
  int n_disp, n_pulse, n_rej, bad_hi, bad_lo, timed_out, first_disp;
  logic [23:0] rq[$];

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_total = n_total + 1;
    assert (obs === exp_v) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h required=%0h", tag, obs, exp_v);
  endtask

  function automatic int bcd(input int c);
    return (c / 10) * 16 + (c % 10);
  endfunction

  task automatic press(input logic [3:0] key);
    @(posedge sclk); #1 bus.flag_key = key;
    @(posedge sclk); #1 bus.flag_key = 4'b0000;
  endtask

  // Watch outputs until the machine is back in IDLE/CREDIT and quiet.
  task automatic settle();
    logic prev_cp;
    logic [23:0] last;
    int hi_run, lo_run;
    n_disp = 0; n_pulse = 0; n_rej = 0; bad_hi = 0; bad_lo = 0;
    timed_out = 1; first_disp = -1;
    hi_run = 0; lo_run = 0; prev_cp = 1'b0;
    rq.delete();
    last = bus.rNum;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge sclk);
      if (bus.dispense) begin
        if (first_disp < 0) first_disp = cyc;
        n_disp++;
      end
      if (bus.reject) n_rej++;
      if (bus.change_pulse && !prev_cp) begin
        if (n_pulse > 0 && lo_run != 2) bad_lo++;
        n_pulse++;
        lo_run = 0;
      end
      if (bus.change_pulse) hi_run++;
      if (!bus.change_pulse && prev_cp) begin
        if (hi_run != 2) bad_hi++;
        hi_run = 0;
      end
      if (!bus.change_pulse && n_pulse > 0) lo_run++;
      if (bus.rNum != last) rq.push_back(bus.rNum);
      last = bus.rNum;
      prev_cp = bus.change_pulse;
      if (cyc >= 4 && (bus.led == 4'b0001 || bus.led == 4'b0010) &&
          !bus.dispense && !bus.change_pulse) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  // One key event: predict from the pricing rules, apply, observe, compare.
  task automatic txn(input string tag, input logic [3:0] key);
    int ed, ep, er, v;
    ed = 0; ep = 0; er = 0;
    if (key[3]) begin
      ep = credit_m / 5;
      credit_m = 0;
    end else if (key[2]) begin
      if (credit_m >= 25) begin
        ed = 4;
        ep = (credit_m - 25) / 5;
        credit_m = 0;
      end else begin
        er = 1;
      end
    end else if (key[1] || key[0]) begin
      v = key[1] ? 10 : 5;
      if (credit_m + v <= 95) credit_m = credit_m + v;
      else er = 1;
    end
    press(key);
    settle();
    chk({tag, ".timeout"}, timed_out, 0);
    chk({tag, ".rnum"}, int'(bus.rNum), bcd(credit_m));
    chk({tag, ".led"}, int'(bus.led), (credit_m == 0) ? 1 : 2);
    chk({tag, ".disp"}, n_disp, ed);
    chk({tag, ".pulses"}, n_pulse, ep);
    chk({tag, ".reject"}, n_rej, er);
    chk({tag, ".hiwidth"}, bad_hi, 0);
    chk({tag, ".lowidth"}, bad_lo, 0);
    if (ed > 0) chk({tag, ".disp_start"}, first_disp, 0);
  endtask

  initial begin
    int r, saw;
    logic [3:0] key;
    bus.flag_key = 4'b0000;
    rst = 1'b1;
    repeat (3) @(posedge sclk);
    @(negedge sclk) rst = 1'b0;
    @(negedge sclk);
    chk("reset.rnum", int'(bus.rNum), 0);
    chk("reset.led", int'(bus.led), 1);
    chk("reset.disp", int'(bus.dispense), 0);
    chk("reset.cp", int'(bus.change_pulse), 0);
    chk("reset.reject", int'(bus.reject), 0);

    // Latency: credit at N+1, rNum and led at N+2
    press(4'b0010);
    @(negedge sclk);
    chk("lat.rnum_n1", int'(bus.rNum), 0);
    chk("lat.led_n1", int'(bus.led), 1);
    @(posedge sclk); #1;
    chk("lat.rnum_n2", int'(bus.rNum), 'h10);
    chk("lat.led_n2", int'(bus.led), 2);
    credit_m = 10;
    settle();

    txn("c10b", 4'b0010);
    txn("c5", 4'b0001);
    txn("buy25", 4'b0100);

    repeat (4) txn("to40", 4'b0010);
    txn("buy40", 4'b0100);
    chk("buy40.steps", rq.size(), 4);
    if (rq.size() == 4) begin
      chk("buy40.s0", int'(rq[0]), 'h15);
      chk("buy40.s1", int'(rq[1]), 'h10);
      chk("buy40.s2", int'(rq[2]), 'h05);
      chk("buy40.s3", int'(rq[3]), 'h00);
    end

    repeat (2) txn("to20", 4'b0010);
    txn("buy20", 4'b0100);
    repeat (7) txn("to90", 4'b0010);
    txn("over90", 4'b0010);
    txn("to95", 4'b0001);
    txn("cancel95", 4'b1000);

    repeat (3) txn("to30", 4'b0010);
    txn("all_keys", 4'b1111);

    // Reset in the middle of a payout
    repeat (3) txn("to30b", 4'b0010);
    press(4'b1000);
    saw = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sclk);
      if (bus.change_pulse) begin
        saw = 1;
        break;
      end
    end
    chk("midrst.saw_pulse", saw, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst.cp", int'(bus.change_pulse), 0);
    chk("midrst.disp", int'(bus.dispense), 0);
    chk("midrst.reject", int'(bus.reject), 0);
    chk("midrst.rnum", int'(bus.rNum), 0);
    chk("midrst.led", int'(bus.led), 1);
    credit_m = 0;
    @(negedge sclk) rst = 1'b0;
    saw = 0;
    repeat (12) begin
      @(negedge sclk);
      if (bus.change_pulse) saw = 1;
    end
    chk("midrst.no_resume", saw, 0);
    chk("midrst.led_after", int'(bus.led), 1);

    // Random key sequences
    repeat (60) begin
      r = $urandom_range(0, 99);
      if (r < 35)      key = 4'b0001;
      else if (r < 65) key = 4'b0010;
      else if (r < 80) key = 4'b0100;
      else if (r < 88) key = 4'b1000;
      else             key = 4'($urandom_range(1, 15));
      txn("rnd", key);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
